// File: rtl/exc_ctrl_pkg.sv
// ============================================================================
// exc_ctrl_pkg : exception codes, vector addresses and FSM states for exc_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

package exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;
   localparam logic [4:0] EXC_TR   = 5'h0D;

   localparam logic [31:0] VEC_BEV1_DEFAULT = 32'hBFC00380;
   localparam logic [31:0] VEC_BEV0_DEFAULT = 32'h80000180;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } exc_state_t;

endpackage

`default_nettype wire

// File: rtl/exc_prio.sv
// ============================================================================
// exc_prio : combinational MIPS exception priority selector
// Config   : EXC_TRAP_EN enables the Tr slot; otherwise m_tr is ignored
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_prio
   import exc_ctrl_pkg::*;
(
   input  logic       int_req,
   input  logic       m_adel_if,
   input  logic       m_ri,
   input  logic       m_ov,
   input  logic       m_tr,
   input  logic       m_sys,
   input  logic       m_bp,
   input  logic       m_adel_d,
   input  logic       m_ades_d,
   input  logic       m_eret,
   output logic       any,
   output logic [4:0] excode,
   output logic       use_pc_bad,
   output logic       use_daddr_bad,
   output logic       is_eret
);

   logic w_tr;
`ifdef EXC_TRAP_EN
   assign w_tr = m_tr;
`else
   logic w_unused_tr;
   assign w_unused_tr = m_tr;
   assign w_tr        = 1'b0;
`endif

   always_comb begin
      any           = int_req | m_adel_if | m_ri | m_ov | w_tr | m_sys |
                      m_bp | m_adel_d | m_ades_d | m_eret;
      excode        = EXC_INT;
      use_pc_bad    = 1'b0;
      use_daddr_bad = 1'b0;
      is_eret       = 1'b0;
      if (int_req) begin
         excode = EXC_INT;
      end else if (m_adel_if) begin
         excode     = EXC_ADEL;
         use_pc_bad = 1'b1;
      end else if (m_ri) begin
         excode = EXC_RI;
      end else if (m_ov) begin
         excode = EXC_OV;
`ifdef EXC_TRAP_EN
      end else if (w_tr) begin
         excode = EXC_TR;
`endif
      end else if (m_sys) begin
         excode = EXC_SYS;
      end else if (m_bp) begin
         excode = EXC_BP;
      end else if (m_adel_d) begin
         excode        = EXC_ADEL;
         use_daddr_bad = 1'b1;
      end else if (m_ades_d) begin
         excode        = EXC_ADES;
         use_daddr_bad = 1'b1;
      end else if (m_eret) begin
         is_eret = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// exc_ctrl : commit-point exception controller feeding CP0 and fetch redirect
// Config   : EXC_TRAP_EN (passed through to exc_prio)
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] VEC_BEV1 = VEC_BEV1_DEFAULT,
   parameter logic [31:0] VEC_BEV0 = VEC_BEV0_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m_valid,
   input  logic        m_stall,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic        m_adel_if,
   input  logic        m_ri,
   input  logic        m_ov,
   input  logic        m_tr,
   input  logic        m_sys,
   input  logic        m_bp,
   input  logic        m_adel_d,
   input  logic        m_ades_d,
   input  logic        m_eret,
   input  logic [31:0] m_daddr,
   input  logic        int_req,
   input  logic        status_bev,
   input  logic [31:0] cp0_epc,
   output logic        mem_kill,
   output logic        exc_valid,
   output logic [4:0]  exc_excode,
   output logic        exc_bd,
   output logic [31:0] exc_epc,
   output logic [31:0] exc_badvaddr,
   output logic        exc_eret,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   exc_state_t  r_state, w_state_nxt;
   logic        w_any, w_use_pc_bad, w_use_daddr_bad, w_is_eret, w_take;
   logic [4:0]  w_excode;
   logic        w_flush, w_redirect_valid;
   logic        r_exc_valid, r_bd, r_eret;
   logic [4:0]  r_excode;
   logic [31:0] r_epc, r_badvaddr, r_redirect_pc;

   exc_prio u_prio (
      .int_req       (int_req),
      .m_adel_if     (m_adel_if),
      .m_ri          (m_ri),
      .m_ov          (m_ov),
      .m_tr          (m_tr),
      .m_sys         (m_sys),
      .m_bp          (m_bp),
      .m_adel_d      (m_adel_d),
      .m_ades_d      (m_ades_d),
      .m_eret        (m_eret),
      .any           (w_any),
      .excode        (w_excode),
      .use_pc_bad    (w_use_pc_bad),
      .use_daddr_bad (w_use_daddr_bad),
      .is_eret       (w_is_eret)
   );

   // Commit inputs seen while redirecting are wrong-path, so only IDLE may take.
   assign w_take   = (r_state == ST_IDLE) & m_valid & ~m_stall & w_any;
   assign mem_kill = w_take;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_flush          = 1'b0;
      w_redirect_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_take) w_state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            w_flush          = 1'b1;
            w_redirect_valid = 1'b1;
            if (redirect_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_exc_valid   <= 1'b0;
         r_excode      <= 5'h00;
         r_bd          <= 1'b0;
         r_epc         <= 32'h0;
         r_badvaddr    <= 32'h0;
         r_eret        <= 1'b0;
         r_redirect_pc <= 32'h0;
      end else begin
         r_exc_valid <= w_take;
         if (w_take) begin
            r_excode   <= w_excode;
            r_bd       <= m_bd;
            r_epc      <= m_bd ? (m_pc - 32'd4) : m_pc;
            r_badvaddr <= w_use_pc_bad    ? m_pc    :
                          w_use_daddr_bad ? m_daddr : 32'h0;
            r_eret     <= w_is_eret;
            r_redirect_pc <= w_is_eret ? cp0_epc : (status_bev ? VEC_BEV1 : VEC_BEV0);
         end
      end
   end

   assign exc_valid      = r_exc_valid;
   assign exc_excode     = r_excode;
   assign exc_bd         = r_bd;
   assign exc_epc        = r_epc;
   assign exc_badvaddr   = r_badvaddr;
   assign exc_eret       = r_eret;
   assign flush          = w_flush;
   assign redirect_valid = w_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// tb_exc_ctrl : scoreboard bench for exc_ctrl (directed vectors)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

   logic        clk, resetn;
   logic        m_valid, m_stall, m_bd;
   logic [31:0] m_pc, m_daddr, cp0_epc;
   logic        m_adel_if, m_ri, m_ov, m_tr, m_sys, m_bp, m_adel_d, m_ades_d, m_eret;
   logic        int_req, status_bev, redirect_ready;
   logic        mem_kill, exc_valid, exc_bd, exc_eret, flush, redirect_valid;
   logic [4:0]  exc_excode;
   logic [31:0] exc_epc, exc_badvaddr, redirect_pc;

   exc_ctrl dut (
      .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_stall(m_stall), .m_pc(m_pc),
      .m_bd(m_bd), .m_adel_if(m_adel_if), .m_ri(m_ri), .m_ov(m_ov), .m_tr(m_tr),
      .m_sys(m_sys), .m_bp(m_bp), .m_adel_d(m_adel_d), .m_ades_d(m_ades_d),
      .m_eret(m_eret), .m_daddr(m_daddr), .int_req(int_req), .status_bev(status_bev),
      .cp0_epc(cp0_epc), .mem_kill(mem_kill), .exc_valid(exc_valid),
      .exc_excode(exc_excode), .exc_bd(exc_bd), .exc_epc(exc_epc),
      .exc_badvaddr(exc_badvaddr), .exc_eret(exc_eret), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  excode;
      logic        bd;
      logic [31:0] epc;
      logic [31:0] badvaddr;
      logic        eret;
      logic [31:0] rpc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] code, input logic bd, input logic [31:0] epc,
                               input logic [31:0] bad, input logic eret, input logic [31:0] rpc);
      exp_t e;
      e.excode = code; e.bd = bd; e.epc = epc; e.badvaddr = bad; e.eret = eret; e.rpc = rpc;
      return e;
   endfunction

   // Monitor: every exc_valid pulse must match the oldest expected report.
   always @(negedge clk) begin
      if (exc_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_report", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("excode",   {27'd0, exc_excode}, {27'd0, e.excode});
            chk("bd",       {31'd0, exc_bd},     {31'd0, e.bd});
            chk("epc",      exc_epc,             e.epc);
            chk("badvaddr", exc_badvaddr,        e.badvaddr);
            chk("eret",     {31'd0, exc_eret},   {31'd0, e.eret});
            chk("rpc",      redirect_pc,         e.rpc);
            chk("flush_with_report", {31'd0, flush}, 32'd1);
         end
      end
   end

   task automatic clear_inputs();
      m_valid = 0; m_stall = 0; m_bd = 0; m_pc = 32'h0; m_daddr = 32'h0;
      m_adel_if = 0; m_ri = 0; m_ov = 0; m_tr = 0; m_sys = 0; m_bp = 0;
      m_adel_d = 0; m_ades_d = 0; m_eret = 0; int_req = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Caller has driven the excepting instruction just after a posedge.
   // Redirect_ready is low for d REDIRECT cycles, so flush lasts d+1 cycles.
   task automatic take_case(input exp_t e, input int d, input bit tog);
      int cnt;
      bit done;
      @(negedge clk);
      chk("mem_kill_take", {31'd0, mem_kill}, 32'd1);
      chk("flush_idle",    {31'd0, flush},    32'd0);
      exp_q.push_back(e);
      next_cycle();
      clear_inputs();
      redirect_ready = (d == 0);
      m_ov = tog;
      m_valid = 1'b0;
      cnt = 0;
      done = 0;
      for (int j = 0; j < 50 && !done; j++) begin
         @(negedge clk);
         if (flush === 1'b1) begin
            cnt++;
            chk("rv_with_flush", {31'd0, redirect_valid}, 32'd1);
            chk("no_kill_redirect", {31'd0, mem_kill}, 32'd0);
            next_cycle();
            redirect_ready = ((j + 1) >= d);
            m_valid = tog & ((j + 1) <= d) & ((j + 1) % 2 == 1);
         end else begin
            done = 1;
         end
      end
      chk("flush_len", cnt, d + 1);
      chk("rv_idle", {31'd0, redirect_valid}, 32'd0);
      clear_inputs();
      redirect_ready = 1'b1;
   endtask

   initial begin
      clear_inputs();
      status_bev = 1; cp0_epc = 32'h0; redirect_ready = 1;
      resetn = 0;
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'h0);
      chk("rst_epc", exc_epc, 32'h0);
      next_cycle();
      resetn = 1;

      // Syscall, BEV=1
      next_cycle();
      m_valid = 1; m_sys = 1; m_pc = 32'hBFC00100; status_bev = 1;
      take_case(mk(5'h08, 0, 32'hBFC00100, 32'h0, 0, 32'hBFC00380), 0, 0);

      // AdES in a delay slot, BEV=0
      next_cycle();
      m_valid = 1; m_ades_d = 1; m_daddr = 32'h80001003; m_bd = 1; m_pc = 32'h80000010;
      status_bev = 0;
      take_case(mk(5'h05, 1, 32'h8000000C, 32'h80001003, 0, 32'h80000180), 0, 0);

      // Interrupt waits through bubbles, then beats RI
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         int_req = 1; m_valid = 0; m_ri = 1; m_pc = 32'h80000400;
         @(negedge clk);
         chk("bubble_no_take", {31'd0, mem_kill}, 32'd0);
      end
      next_cycle();
      m_valid = 1;
      take_case(mk(5'h00, 0, 32'h80000400, 32'h0, 0, 32'h80000180), 0, 0);

      // ERET
      next_cycle();
      m_valid = 1; m_eret = 1; m_pc = 32'h80000050; cp0_epc = 32'h80000234;
      take_case(mk(5'h00, 0, 32'h80000050, 32'h0, 1, 32'h80000234), 0, 0);

      // Ov with fetch stalled 4 cycles; wrong-path Ov toggles must not take
      next_cycle();
      m_valid = 1; m_ov = 1; m_sys = 1; m_pc = 32'h80000060; status_bev = 1;
      take_case(mk(5'h0C, 0, 32'h80000060, 32'h0, 0, 32'hBFC00380), 4, 1);

      // Fetch AdEL outranks RI and data AdEL
      next_cycle();
      m_valid = 1; m_adel_if = 1; m_ri = 1; m_adel_d = 1; m_pc = 32'h00000003;
      m_daddr = 32'h12345678;
      take_case(mk(5'h04, 0, 32'h00000003, 32'h00000003, 0, 32'hBFC00380), 0, 0);

      // Bp outranks data AdEL; EPC wraps below zero in a delay slot
      next_cycle();
      m_valid = 1; m_bp = 1; m_adel_d = 1; m_bd = 1; m_pc = 32'h00000000;
      m_daddr = 32'h00000001; status_bev = 0;
      take_case(mk(5'h09, 1, 32'hFFFFFFFC, 32'h0, 0, 32'h80000180), 0, 0);

      // Data AdEL alone
      next_cycle();
      m_valid = 1; m_adel_d = 1; m_pc = 32'h80000070; m_daddr = 32'h80002002;
      take_case(mk(5'h04, 0, 32'h80000070, 32'h80002002, 0, 32'h80000180), 0, 0);

      // Stalled instruction never takes
      next_cycle();
      m_valid = 1; m_stall = 1; m_sys = 1;
      @(negedge clk);
      chk("stall_no_take", {31'd0, mem_kill}, 32'd0);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("stall_no_flush", {31'd0, flush}, 32'd0);

      // Trap alone
      next_cycle();
      m_valid = 1; m_tr = 1; m_pc = 32'h80000080;
`ifdef EXC_TRAP_EN
      take_case(mk(5'h0D, 0, 32'h80000080, 32'h0, 0, 32'h80000180), 0, 0);
`else
      @(negedge clk);
      chk("trap_no_take", {31'd0, mem_kill}, 32'd0);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("trap_no_flush", {31'd0, flush}, 32'd0);
`endif

      // Reset in the middle of a redirect
      next_cycle();
      m_valid = 1; m_sys = 1; m_pc = 32'h80000090; status_bev = 1;
      exp_q.push_back(mk(5'h08, 0, 32'h80000090, 32'h0, 0, 32'hBFC00380));
      redirect_ready = 0;
      next_cycle();
      clear_inputs();
      resetn = 0;
      next_cycle();
      @(negedge clk);
      chk("rst_mid_flush", {31'd0, flush}, 32'd0);
      chk("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_mid_exc_valid", {31'd0, exc_valid}, 32'd0);
      chk("rst_mid_excode", {27'd0, exc_excode}, 32'd0);
      chk("rst_mid_rpc", redirect_pc, 32'h0);
      chk("rst_mid_epc", exc_epc, 32'h0);
      next_cycle();
      resetn = 1; redirect_ready = 1;

      repeat (3) next_cycle();
      chk("exp_q_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
